bios_download_ctrl: RTL

//  Sits between hps_io ioctl download outputs and the system block's dn_* port.

---
 rtl/bios_download_ctrl.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/bios_download_ctrl.sv
// bios_download_ctrl
// Bridges the hps_io ioctl download port to the system block's dn_* write port.
// ROM/BIOS indices (ioctl_index <= INDEX_MAX) hold the core in reset for the whole
// download plus HOLD_CYCLES afterwards, and keep a byte count, a 16-bit checksum
// and a sticky out-of-window flag. Other indices are forwarded without side effects.
module bios_download_ctrl #(
    parameter int ADDR_W      = 14,
    parameter int INDEX_MAX   = 1,
    parameter int HOLD_CYCLES = 16
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              ioctl_download,
    input  logic              ioctl_wr,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    input  logic [7:0]        ioctl_index,
    output logic [ADDR_W-1:0] dn_addr,
    output logic [7:0]        dn_data,
    output logic              dn_wr,
    output logic [7:0]        dn_index,
    output logic              core_reset,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   byte_count,
    output logic [15:0]       checksum,
    output logic              overflow
);

    // Controller states.
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;
    localparam logic [1:0] S_PASS = 2'd3;

    // The hold counter only ever holds HOLD_CYCLES-1 down to 0.
    localparam int HCW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HCW-1:0] HOLD_LOAD = HCW'(HOLD_CYCLES - 1);

    localparam logic [7:0]    IDX_MAX = 8'(INDEX_MAX);
    localparam logic [ADDR_W:0] CNT_MAX = (ADDR_W+1)'(1) << ADDR_W;

    logic [1:0]        state_q,      state_d;
    logic [HCW-1:0]    hold_q,       hold_d;
    logic              dl_prev_q;
    logic              dn_wr_q,      dn_wr_d;
    logic [ADDR_W-1:0] dn_addr_q,    dn_addr_d;
    logic [7:0]        dn_data_q,    dn_data_d;
    logic [7:0]        dn_index_q,   dn_index_d;
    logic              core_reset_q, core_reset_d;
    logic              done_q,       done_d;
    logic [ADDR_W:0]   count_q,      count_d;
    logic [15:0]       sum_q,        sum_d;
    logic              ovf_q,        ovf_d;

    logic dl_rise;
    logic rom_idx;
    logic in_win;
    logic fwd_en;
    logic counting;

    assign dl_rise  = ioctl_download & ~dl_prev_q;
    assign rom_idx  = (ioctl_index <= IDX_MAX);
    // Anything with a bit set above the window is out of range for the system RAM.
    assign in_win   = ((ioctl_addr >> ADDR_W) == 25'd0);
    // Writes are forwarded only while a download is being serviced.
    assign fwd_en   = (state_q == S_LOAD) || (state_q == S_PASS);
    // Only ROM downloads feed the statistics.
    assign counting = (state_q == S_LOAD);

    // Next-state logic: FSM, write forwarding and download statistics.
    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        dn_wr_d      = 1'b0;
        dn_addr_d    = dn_addr_q;
        dn_data_d    = dn_data_q;
        dn_index_d   = dn_index_q;
        core_reset_d = core_reset_q;
        done_d       = done_q;
        count_d      = count_q;
        sum_d        = sum_q;
        ovf_d        = ovf_q;

        // Write path first: a strobe in the same cycle the download falls still lands.
        if (fwd_en && ioctl_wr) begin
            if (in_win) begin
                dn_wr_d   = 1'b1;
                dn_addr_d = ioctl_addr[ADDR_W-1:0];
                dn_data_d = ioctl_dout;
                if (counting) begin
                    if (count_q != CNT_MAX) begin
                        count_d = count_q + 1'b1;
                    end
                    sum_d = sum_q + {8'h00, ioctl_dout};
                end
            end else if (counting) begin
                ovf_d = 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (dl_rise) begin
                    dn_index_d = ioctl_index;
                    if (rom_idx) begin
                        state_d      = S_LOAD;
                        core_reset_d = 1'b1;
                        done_d       = 1'b0;
                        count_d      = '0;
                        sum_d        = '0;
                        ovf_d        = 1'b0;
                    end else begin
                        state_d = S_PASS;
                    end
                end
            end
            S_LOAD: begin
                if (!ioctl_download) begin
                    state_d = S_HOLD;
                    hold_d  = HOLD_LOAD;
                end
            end
            S_HOLD: begin
                // A fresh ROM download restarts the load without releasing reset.
                if (dl_rise && rom_idx) begin
                    state_d      = S_LOAD;
                    dn_index_d   = ioctl_index;
                    core_reset_d = 1'b1;
                    done_d       = 1'b0;
                    count_d      = '0;
                    sum_d        = '0;
                    ovf_d        = 1'b0;
                end else if (hold_q == '0) begin
                    state_d      = S_IDLE;
                    core_reset_d = 1'b0;
                    done_d       = 1'b1;
                end else begin
                    hold_d = hold_q - 1'b1;
                end
            end
            S_PASS: begin
                if (!ioctl_download) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d      = S_IDLE;
                core_reset_d = 1'b0;
            end
        endcase
    end

    // State registers; async reset aborts any download immediately.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            hold_q       <= '0;
            dl_prev_q    <= 1'b0;
            dn_wr_q      <= 1'b0;
            dn_addr_q    <= '0;
            dn_data_q    <= '0;
            dn_index_q   <= '0;
            core_reset_q <= 1'b0;
            done_q       <= 1'b0;
            count_q      <= '0;
            sum_q        <= '0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            dl_prev_q    <= ioctl_download;
            dn_wr_q      <= dn_wr_d;
            dn_addr_q    <= dn_addr_d;
            dn_data_q    <= dn_data_d;
            dn_index_q   <= dn_index_d;
            core_reset_q <= core_reset_d;
            done_q       <= done_d;
            count_q      <= count_d;
            sum_q        <= sum_d;
            ovf_q        <= ovf_d;
        end
    end

    assign dn_addr    = dn_addr_q;
    assign dn_data    = dn_data_q;
    assign dn_wr      = dn_wr_q;
    assign dn_index   = dn_index_q;
    assign core_reset = core_reset_q;
    assign busy       = (state_q == S_LOAD) || (state_q == S_HOLD);
    assign done       = done_q;
    assign byte_count = count_q;
    assign checksum   = sum_q;
    assign overflow   = ovf_q;

endmodule
